// File: rtl/seq_mult_pkg.sv
// Shared constants and state encoding for the 4x4 sequential shift-and-add multiplier.
package seq_mult_pkg;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned PROD_W = 2 * WIDTH;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the ripple-carry adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca.sv
// 4-bit ripple-carry adder built from full_adder cells.
module rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[4];

    for (genvar i = 0; i < 4; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/seq_mult.sv
// 4x4 unsigned shift-and-add multiplier: one rca-based add/shift step per clock.
// Optional SEQ_MULT_EARLY_EXIT_EN: zero operands complete on the accepting edge.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = seq_mult_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // The shared adder is a fixed 4-bit instance, so no other width can work.
    if (WIDTH != 4) begin : g_width_chk
        $error("seq_mult: WIDTH must be 4");
    end

    state_e             state, state_nxt;
    logic [WIDTH-1:0]   m, m_nxt;
    logic [WIDTH-1:0]   acc, acc_nxt;
    logic [WIDTH-1:0]   q, q_nxt;
    logic               c, c_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [2*WIDTH-1:0] prod_nxt;
    logic               busy_nxt, done_nxt;

    logic [WIDTH-1:0]   add_sum;
    logic               add_co;
    logic [WIDTH-1:0]   step_a;
    logic               step_c;

    rca u_rca (
        .a    (acc),
        .b    (m),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_nxt = state;
        m_nxt     = m;
        acc_nxt   = acc;
        q_nxt     = q;
        c_nxt     = c;
        cnt_nxt   = cnt;
        prod_nxt  = product;
        step_c    = 1'b0;
        step_a    = acc;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    m_nxt     = a;
                    q_nxt     = b;
                    acc_nxt   = '0;
                    c_nxt     = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = CALC;
`ifdef SEQ_MULT_EARLY_EXIT_EN
                    if ((a == '0) || (b == '0)) begin
                        state_nxt = DONE;
                        prod_nxt  = '0;
                    end
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end

            CALC: begin
                if (q[0]) begin
                    step_c = add_co;
                    step_a = add_sum;
                end
                // {C,A,Q} shifts right one place with a zero entering at the top.
                c_nxt   = 1'b0;
                acc_nxt = {step_c, step_a[WIDTH-1:1]};
                q_nxt   = {step_a[0], q[WIDTH-1:1]};
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    prod_nxt  = {acc_nxt, q_nxt};
                    state_nxt = DONE;
                end
            end

            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == CALC);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            m       <= m_nxt;
            acc     <= acc_nxt;
            q       <= q_nxt;
            c       <= c_nxt;
            cnt     <= cnt_nxt;
            product <= prod_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: vector table plus directed multi-cycle sequences.
module tb_seq_mult;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] prod;
        int         lat;
        int         nbusy;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    seq_mult dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always @(negedge clk) begin
        if (rst_n && done) done_seen++;
    end

    task automatic check(input string tag, input string what, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d, expected %0d", tag, what, act, exp);
        end
    endtask

    // Start one operation and sample each following cycle until done (bounded).
    task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input string tag,
                          input logic [7:0] exp_p, input int exp_lat, input int exp_busy,
                          input logic [7:0] prev_p);
        int lat;
        int nbusy;
        int nchg;
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = ~ia;
        b = ~ib;
        lat = -1;
        nbusy = 0;
        nchg = 0;
        for (int n = 0; n < 12; n++) begin
            if (n > 0) @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                lat = n + 1;
                break;
            end
            if (product != prev_p) nchg++;
        end
        check(tag, "latency", lat, exp_lat);
        check(tag, "busy_cycles", nbusy, exp_busy);
        check(tag, "product", int'(product), int'(exp_p));
        check(tag, "early_product_change", nchg, 0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev;
        int         k;
        int         d0;

        vecs[0] = '{4'd13, 4'd11, 8'h8F, 5, 4};
        vecs[1] = '{4'd15, 4'd15, 8'hE1, 5, 4};
        vecs[2] = '{4'd0,  4'd9,  8'h00, EARLY ? 1 : 5, EARLY ? 0 : 4};
        vecs[3] = '{4'd1,  4'd15, 8'h0F, 5, 4};
        vecs[4] = '{4'd10, 4'd0,  8'h00, EARLY ? 1 : 5, EARLY ? 0 : 4};
        vecs[5] = '{4'd8,  4'd8,  8'h40, 5, 4};
        vecs[6] = '{4'd12, 4'd5,  8'h3C, 5, 4};
        vecs[7] = '{4'd3,  4'd5,  8'h0F, 5, 4};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("reset", "busy", int'(busy), 0);
        check("reset", "done", int'(done), 0);
        check("reset", "product", int'(product), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle", "busy", int'(busy), 0);
        check("idle", "done", int'(done), 0);

        prev = 8'h00;
        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d_%0dx%0d", i, vecs[i].a, vecs[i].b);
            run_op(vecs[i].a, vecs[i].b, tag, vecs[i].prod, vecs[i].lat, vecs[i].nbusy, prev);
            @(negedge clk);
            check(tag, "done_after_pulse", int'(done), 0);
            check(tag, "product_held", int'(product), int'(vecs[i].prod));
            prev = vecs[i].prod;
        end

        // start during CALC is ignored and new operands are not captured
        d0 = done_seen;
        @(negedge clk);
        a = 4'd7;
        b = 4'd6;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 4'd1;
        b = 4'd1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        check("ignore", "wait_cycles", k, 2);
        check("ignore", "product", int'(product), 8'h2A);
        repeat (3) @(negedge clk);
        check("ignore", "done_pulses", done_seen - d0, 1);
        check("ignore", "product_held", int'(product), 8'h2A);
        check("ignore", "busy_idle", int'(busy), 0);

        // asynchronous reset in the second CALC cycle
        @(negedge clk);
        a = 4'd13;
        b = 4'd11;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midreset", "busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midreset", "busy", int'(busy), 0);
        check("midreset", "done", int'(done), 0);
        check("midreset", "product", int'(product), 0);
        d0 = done_seen;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midreset", "done_after_release", done_seen - d0, 0);
        check("midreset", "product_after_release", int'(product), 0);
        check("midreset", "busy_after_release", int'(busy), 0);

        // back-to-back: start held high in the DONE cycle
        d0 = done_seen;
        run_op(4'd3, 4'd5, "b2b_first", 8'h0F, 5, 4, 8'h00);
        a = 4'd9;
        b = 4'd4;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_second", "busy", int'(busy), 1);
        check("b2b_second", "product_hold", int'(product), 8'h0F);
        wait_done(k);
        check("b2b_second", "wait_cycles", k, 4);
        check("b2b_second", "product", int'(product), 8'h24);
        repeat (2) @(negedge clk);
        check("b2b", "done_pulses", done_seen - d0, 2);
        check("b2b", "product_held", int'(product), 8'h24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
